// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton conditioning path: channel states,
// 50 MHz default timing constants and a small width helper.
package key_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } key_state_e;

   localparam int unsigned DEBOUNCE_20MS       = 1_000_000;
   localparam int unsigned REPEAT_DELAY_500MS  = 25_000_000;
   localparam int unsigned REPEAT_PERIOD_200MS = 10_000_000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton channel: synchronizer, polarity normalization, debounce FSM
// and hold-to-repeat step generation. All outputs are registered.
module key_channel
   import key_pkg::*;
#(
   parameter int unsigned ACTIVE_LOW      = 1,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter int unsigned REPEAT_EN       = 1,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_500MS,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_200MS
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_step
);

   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned RCNT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] RD_LAST  = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] RP_LAST  = RCNT_W'(REPEAT_PERIOD - 1);
   localparam logic              IDLE_LVL = (ACTIVE_LOW != 0);

   logic [1:0]        sync_q;
   logic              p_q;
   key_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic              first_q, first_d;
   logic              level_q, level_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              step_q, step_d;

   // p_q is the normalized pressed flag; it is registered so p lands two edges
   // after the raw pin is first captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {2{IDLE_LVL}};
         p_q    <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], key_raw};
         p_q    <= sync_q[1] ^ IDLE_LVL;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rcnt_d    = rcnt_q;
      first_d   = first_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      step_d    = 1'b0;
      case (state_q)
         ST_RELEASED: begin
            if (p_q) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!p_q) begin
               state_d = ST_RELEASED;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_HELD;
               level_d = 1'b1;
               press_d = 1'b1;
               step_d  = 1'b1;
               rcnt_d  = '0;
               first_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (!p_q) begin
               state_d = ST_RELEASE_WAIT;
               cnt_d   = '0;
            end else if (REPEAT_EN != 0) begin
               // first_q selects the initial delay versus the steady period
               if (rcnt_q == (first_q ? RD_LAST : RP_LAST)) begin
                  step_d  = 1'b1;
                  rcnt_d  = '0;
                  first_d = 1'b0;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
         end
         ST_RELEASE_WAIT: begin
            if (p_q) begin
               state_d = ST_HELD;
               rcnt_d  = '0;
               first_d = 1'b0;
            end else if (cnt_q == DB_LAST) begin
               state_d   = ST_RELEASED;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_RELEASED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RELEASED;
         cnt_q     <= '0;
         rcnt_q    <= '0;
         first_q   <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rcnt_q    <= rcnt_d;
         first_q   <= first_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         step_q    <= step_d;
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_step    = step_q;

endmodule

// File: rtl/key_conditioner.sv
// Board pushbutton conditioner: N_KEYS independent debounced channels producing
// level, press, release and auto-repeat step pulses.
module key_conditioner
   import key_pkg::*;
#(
   parameter int unsigned N_KEYS          = 4,
   parameter int unsigned ACTIVE_LOW      = 1,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter int unsigned REPEAT_EN       = 1,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_500MS,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_200MS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_step
);

   generate
      for (genvar gi = 0; gi < int'(N_KEYS); gi++) begin : g_chan
         key_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
         ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .key_raw     (key_raw[gi]),
            .key_level   (key_level[gi]),
            .key_press   (key_press[gi]),
            .key_release (key_release[gi]),
            .key_step    (key_step[gi])
         );
      end
   endgenerate

endmodule
